// File: rtl/ir_prefetch_decode.sv
// ir_prefetch_decode: byte prefetch queue, multi-byte assembler, decoded issue.
// Optional IR_ILLEGAL_TRAP_EN: illegal opcodes issue as cls=7 and halt.

module ir_prefetch_decode #(
  parameter int DEPTH = 4,
  parameter int OPW   = 8
) (
  input  logic                       CLK,
  input  logic                       RSTn,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [7:0]                 Din,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [7:0]                 opcode,
  output logic [OPW-1:0]             operand,
  output logic [2:0]                 cls,
  output logic [2:0]                 alu_op,
  output logic [1:0]                 alu_mode,
  output logic                       halted,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int AW = $clog2(DEPTH);
  localparam int NB = OPW / 8;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [2:0] CLS_HALT = 3'd4;
  localparam logic [2:0] CLS_ILL  = 3'd7;
`ifdef IR_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef enum logic [1:0] {
    FETCH, OPND, ISSUE, PARK
  } state_t;

  typedef struct packed {
    logic [2:0] cls;
    logic [2:0] alu_op;
    logic [1:0] alu_mode;
    logic       has_opnd;
  } dec_t;

  function automatic dec_t decode(input logic [7:0] b);
    dec_t d;
    logic [7:0] t;
    d = '0;
    t = b - 8'h92;
    unique case (1'b1)
      (b == 8'h90) || (b == 8'h91): begin
        d.cls = 3'd0;
        d.alu_mode = {1'b0, b[0]};
        d.has_opnd = 1'b1;
      end
      (b >= 8'h92) && (b <= 8'hA9): begin
        d.cls = 3'd1;
        d.alu_op = t[4:2];
        d.alu_mode = t[1:0];
      end
      b == 8'hC0: begin
        d.cls = 3'd2;
        d.has_opnd = 1'b1;
      end
      b == 8'hC1: begin
        d.cls = 3'd3;
        d.has_opnd = 1'b1;
      end
      b == 8'hFF: d.cls = CLS_HALT;
      default:    d.cls = CLS_ILL;
    endcase
    return d;
  endfunction

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [0:0]    bcnt;
  state_t        state, state_nxt, op_tgt;
  logic [7:0]    head;
  dec_t          hd;
  logic          push, pop, take_op, take_byte, set_halt;
  logic          nonempty, last_byte, stop_op;

  assign head      = mem[rd_ptr];
  assign hd        = decode(head);
  assign nonempty  = count != '0;
  assign last_byte = bcnt == 1'(NB-1);
  assign stop_op   = (cls == CLS_HALT) || (TRAP && cls == CLS_ILL);
  assign push      = in_valid && in_ready;
  assign op_tgt    = hd.has_opnd ? OPND :
                     ((hd.cls == CLS_ILL) && !TRAP) ? FETCH : ISSUE;

  // State register
  always_ff @(posedge CLK) begin
    if (!RSTn) state <= FETCH;
    else       state <= state_nxt;
  end

  // Next state plus queue/field strobes; flush overrides everything
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    take_op   = 1'b0;
    take_byte = 1'b0;
    set_halt  = 1'b0;
    if (flush) begin
      state_nxt = (state == PARK) ? PARK : FETCH;
    end else begin
      unique case (state)
        FETCH: if (nonempty) begin
          pop       = 1'b1;
          take_op   = 1'b1;
          state_nxt = op_tgt;
        end
        OPND: if (nonempty) begin
          pop       = 1'b1;
          take_byte = 1'b1;
          if (last_byte) state_nxt = ISSUE;
        end
        ISSUE: if (out_ready) begin
          if (stop_op) begin
            set_halt  = 1'b1;
            state_nxt = PARK;
          end else if (nonempty) begin
            pop       = 1'b1;
            take_op   = 1'b1;
            state_nxt = op_tgt;
          end else begin
            state_nxt = FETCH;
          end
        end
        PARK: state_nxt = PARK;
      endcase
    end
  end

  // Handshake outputs
  always_comb begin
    out_valid = (state == ISSUE);
    in_ready  = (count < DEPTH_C) && !halted && !flush;
  end

  // Queue storage, no reset needed
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= Din;
  end

  // Queue pointers, halt flag and decoded fields
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      halted   <= 1'b0;
      bcnt     <= '0;
      opcode   <= '0;
      operand  <= '0;
      cls      <= '0;
      alu_op   <= '0;
      alu_mode <= '0;
    end else begin
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
      if (set_halt) halted <= 1'b1;
      if (take_op) begin
        opcode   <= head;
        cls      <= hd.cls;
        alu_op   <= hd.alu_op;
        alu_mode <= hd.alu_mode;
        operand  <= '0;
        bcnt     <= '0;
      end
      if (take_byte) begin
        if (bcnt == 1'b0) operand[7:0] <= head;
        else              operand[OPW-1 -: 8] <= head;
        bcnt <= bcnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ir_prefetch_decode.sv
// tb_ir_prefetch_decode: scoreboard bench, byte-stream reference model.
// Handles both IR_ILLEGAL_TRAP_EN builds.

module tb_ir_prefetch_decode;

  localparam int DEPTH = 4;
  localparam int OPW   = 16;
  localparam int NB    = OPW / 8;
  localparam int CW    = $clog2(DEPTH+1);
`ifdef IR_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic           CLK = 1'b0;
  logic           RSTn = 1'b0;
  logic           flush = 1'b0;
  logic           in_valid = 1'b0;
  logic           out_ready = 1'b0;
  logic [7:0]     Din = 8'h00;
  logic           in_ready, out_valid, halted;
  logic [7:0]     opcode;
  logic [OPW-1:0] operand;
  logic [2:0]     cls, alu_op;
  logic [1:0]     alu_mode;
  logic [CW-1:0]  count;

  ir_prefetch_decode #(.DEPTH(DEPTH), .OPW(OPW)) dut (
    .CLK(CLK), .RSTn(RSTn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .Din(Din),
    .out_valid(out_valid), .out_ready(out_ready),
    .opcode(opcode), .operand(operand), .cls(cls),
    .alu_op(alu_op), .alu_mode(alu_mode),
    .halted(halted), .count(count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0]  op;
    logic [15:0] opnd;
    logic [2:0]  cls;
    logic [2:0]  aop;
    logic [1:0]  mode;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] pend[$];
  int         hs_cyc[$];
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  bit         m_halted = 1'b0;
  bit         rnd_ready = 1'b0;

  always @(posedge CLK) cyc++;

  function automatic bit needs(input logic [7:0] op);
    return op == 8'h90 || op == 8'h91 || op == 8'hC0 || op == 8'hC1;
  endfunction

  function automatic exp_t model(input logic [7:0] op, input logic [15:0] v);
    exp_t e;
    int k;
    e.op = op; e.opnd = 16'h0; e.aop = 3'd0; e.mode = 2'd0;
    if (op == 8'h90 || op == 8'h91) begin
      e.cls = 3'd0; e.mode = 2'(op - 8'h90); e.opnd = v;
    end else if (op >= 8'h92 && op <= 8'hA9) begin
      k = int'(op) - 'h92;
      e.cls = 3'd1; e.aop = 3'(k / 4); e.mode = 2'(k % 4);
    end else if (op == 8'hC0) begin
      e.cls = 3'd2; e.opnd = v;
    end else if (op == 8'hC1) begin
      e.cls = 3'd3; e.opnd = v;
    end else if (op == 8'hFF) begin
      e.cls = 3'd4;
    end else begin
      e.cls = 3'd7;
    end
    return e;
  endfunction

  function automatic void parse();
    int n;
    logic [15:0] v;
    exp_t e;
    while (pend.size() > 0) begin
      n = needs(pend[0]) ? 1 + NB : 1;
      if (pend.size() < n) break;
      v = (n > 1) ? {pend[2], pend[1]} : 16'h0;
      e = model(pend[0], v);
      repeat (n) void'(pend.pop_front());
      if (e.cls == 3'd7 && !TRAP) continue;
      exp_q.push_back(e);
    end
  endfunction

  // stimulus tracker: accepted bytes feed the model
  always @(negedge CLK) begin
    if (!RSTn || flush) begin
      pend.delete();
      exp_q.delete();
      if (!RSTn) m_halted = 1'b0;
    end else if (in_valid && in_ready) begin
      pend.push_back(Din);
      parse();
    end
  end

  // monitor: compare each issue handshake with the scoreboard
  always @(negedge CLK) begin
    exp_t e;
    if (RSTn && !flush && out_valid && out_ready) begin
      checks++;
      hs_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL issue: got unexpected opcode %h, required none", opcode);
      end else begin
        e = exp_q.pop_front();
        if (opcode !== e.op || operand !== e.opnd || cls !== e.cls ||
            alu_op !== e.aop || alu_mode !== e.mode) begin
          errors++;
          $display("FAIL issue: got op=%h opnd=%h cls=%0d aop=%0d mode=%0d, required op=%h opnd=%h cls=%0d aop=%0d mode=%0d",
                   opcode, operand, cls, alu_op, alu_mode,
                   e.op, e.opnd, e.cls, e.aop, e.mode);
        end
        if (e.cls == 3'd4 || (TRAP && e.cls == 3'd7)) m_halted = 1'b1;
      end
    end
  end

  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string n, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", n, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    int t;
    t = 0;
    in_valid = 1'b1;
    Din = b;
    forever begin
      @(negedge CLK);
      if (in_ready) break;
      t++;
      if (t > 300) begin
        checks++;
        errors++;
        $display("FAIL push_timeout: byte %h not accepted, required acceptance", b);
        break;
      end
    end
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    while (exp_q.size() > 0 && t < 500) begin
      tick(1);
      t++;
    end
    tick(2 * DEPTH + 2);
    chk("drain_exp_empty", exp_q.size(), 0);
    chk("drain_count", int'(count), 0);
    chk("drain_out_valid", int'(out_valid), 0);
  endtask

  task automatic do_reset();
    RSTn = 1'b0;
    tick(1);
    RSTn = 1'b1;
  endtask

  logic [7:0] ill_tab [7] = '{8'h00, 8'h10, 8'h8F, 8'hAA, 8'hBF, 8'hC2, 8'hFE};

  initial begin
    logic [7:0] b;
    int r, c0;

    tick(2);
    RSTn = 1'b1;
    chk("rst_count", int'(count), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_halted", int'(halted), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_opcode", int'(opcode), 0);
    chk("rst_cls", int'(cls), 0);
    chk("rst_operand", int'(operand), 0);

    // single-byte latency
    out_ready = 1'b0;
    push(8'h93);
    chk("lat_e0_valid", int'(out_valid), 0);
    chk("lat_e0_count", int'(count), 1);
    tick(1);
    chk("lat_e1_valid", int'(out_valid), 1);
    chk("lat_e1_count", int'(count), 0);
    chk("lat_e1_cls", int'(cls), 1);
    drain();

    // back-to-back ALU issue
    out_ready = 1'b1;
    hs_cyc.delete();
    push(8'h92);
    push(8'h9F);
    push(8'hA9);
    drain();
    chk("b2b_issues", hs_cyc.size(), 3);
    if (hs_cyc.size() == 3) begin
      chk("b2b_gap1", hs_cyc[1] - hs_cyc[0], 1);
      chk("b2b_gap2", hs_cyc[2] - hs_cyc[1], 1);
    end

    // 16-bit operands, delayed JMP bytes
    push(8'h90);
    push(8'h34);
    push(8'h12);
    push(8'hC1);
    tick(3);
    chk("jmp_stall1", int'(out_valid), 0);
    push(8'h78);
    tick(3);
    chk("jmp_stall2", int'(out_valid), 0);
    push(8'h56);
    drain();

    // full queue back-pressure
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(8'(8'h92 + i));
    chk("full_count", int'(count), DEPTH);
    in_valid = 1'b1;
    Din = 8'h97;
    tick(3);
    chk("full_in_ready", int'(in_ready), 0);
    chk("full_count_hold", int'(count), DEPTH);
    out_ready = 1'b1;
    push(8'h97);
    drain();

    // flush in OPND with a concurrent push
    push(8'hC0);
    push(8'h55);
    tick(2);
    chk("fl_opnd_valid", int'(out_valid), 0);
    in_valid = 1'b1;
    Din = 8'h77;
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_count", int'(count), 0);
    chk("fl_out_valid", int'(out_valid), 0);
    tick(3);
    chk("fl_no_issue", int'(out_valid), 0);
    push(8'h91);
    push(8'h01);
    push(8'h02);
    drain();

    // reset with junk queued
    out_ready = 1'b0;
    push(8'h92);
    push(8'h93);
    push(8'hC1);
    push(8'h11);
    do_reset();
    chk("jrst_count", int'(count), 0);
    chk("jrst_out_valid", int'(out_valid), 0);
    chk("jrst_halted", int'(halted), 0);
    chk("jrst_in_ready", int'(in_ready), 1);
    chk("jrst_opcode", int'(opcode), 0);
    tick(4);
    chk("jrst_idle", int'(out_valid), 0);

    // randomized stream
    rnd_ready = 1'b1;
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 24) == 0) begin
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
      end
      r = $urandom_range(0, 9);
      if (r <= 5)      b = 8'(8'h92 + $urandom_range(0, 23));
      else if (r == 6) b = 8'(8'h90 + $urandom_range(0, 1));
      else if (r == 7) b = 8'hC0;
      else if (r == 8) b = 8'hC1;
      else if (!TRAP)  b = ill_tab[$urandom_range(0, 6)];
      else             b = 8'hA0;
      push(b);
      if (needs(b)) begin
        for (int k = 0; k < NB; k++) begin
          tick($urandom_range(0, 2));
          push(8'($urandom_range(0, 255)));
        end
      end
      tick($urandom_range(0, 1));
    end
    drain();

    // illegal then HALT
    out_ready = 1'b1;
    push(8'h00);
    push(8'hFF);
    tick(6);
    chk("halt_flag", int'(halted), 1);
    chk("halt_model", int'(halted), int'(m_halted));
    chk("halt_in_ready", int'(in_ready), 0);
    chk("halt_out_valid", int'(out_valid), 0);
    chk("halt_leftover", exp_q.size(), TRAP ? 1 : 0);
    c0 = int'(count);
    in_valid = 1'b1;
    Din = 8'h92;
    tick(3);
    chk("halt_no_push", int'(count), c0);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    in_valid = 1'b0;
    tick(2);
    chk("halt_after_flush", int'(halted), 1);
    chk("halt_frozen_valid", int'(out_valid), 0);

    // reset releases halt
    do_reset();
    chk("hrst_halted", int'(halted), 0);
    chk("hrst_in_ready", int'(in_ready), 1);
    push(8'h94);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ir_prefetch_decode.md
# ir_prefetch_decode

Parametrised instruction register for the 8-bit CPU. It replaces the single-byte latch-and-decode stage with a DEPTH-byte prefetch queue, an assembler FSM for multi-byte instructions (opcode plus 1 or 2 operand bytes), and a valid/ready issue port carrying decoded fields. It sits between the program-memory fetch path and the control unit and keeps the existing opcode map (0x90–0xA9 load/ALU, 0xC0 ST, 0xC1 JMP, 0xFF HALT).

## Interface
- DEPTH, 4: prefetch queue depth in bytes; power of two, ≥2.
- OPW, 8: operand width; 8 or 16 (operand bytes NB = OPW/8).
- CLK  in  1  clock, rising edge.
- RSTn  in  1  synchronous, active-low reset.
- flush  in  1  discard queue and any partial instruction (jump redirect).
- in_valid  in  1  fetch byte valid.
- in_ready  out  1  queue can accept a byte.
- Din  in  8  fetched byte.
- out_valid  out  1  decoded instruction held for issue.
- out_ready  in  1  control unit accepts instruction.
- opcode  out  8  raw opcode.
- operand  out  OPW  operand, little-endian assembled; 0 for no-operand instructions.
- cls  out  3  0 LD, 1 ALU, 2 ST, 3 JMP, 4 HALT, 7 ILLEGAL.
- alu_op  out  3  0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 SHL, 5 SHR; 0 when cls≠1.
- alu_mode  out  2  0 A, 1 B, 2 AB, 3 BA; for LD: 0 A, 1 B.
- halted  out  1  HALT issued; block frozen.
- count  out  $clog2(DEPTH+1)  queue occupancy.

## Operation
- Decode: idx = opcode−0x90. idx 0/1 → LD (mode=idx). idx 2..25 → ALU, alu_op=(idx−2)>>2, alu_mode=(idx−2)&3. 0xC0 ST, 0xC1 JMP, 0xFF HALT, all else ILLEGAL.
- LD, ST, JMP carry NB operand bytes; ALU, HALT, ILLEGAL carry none.
- Queue push when in_valid && in_ready. in_ready = (count<DEPTH) && !halted && !flush. No push-on-pop bypass: a full queue refuses input even if popping that cycle.
- FSM states: FETCH (pop opcode when count>0), OPND (pop one operand byte per cycle when count>0; stall when empty), ISSUE (out_valid=1, fields stable until out_ready).
- FETCH→ISSUE for no-operand opcodes; FETCH→OPND→ISSUE after NB bytes.
- ISSUE with out_ready: if count>0, the next opcode is popped on the same edge (FETCH skipped); otherwise go to FETCH.
- HALT handshake sets halted; FSM parks, in_ready=0, out_valid=0 until reset. flush does not clear halted.
- flush: queue emptied, FSM→FETCH, out_valid dropped next edge; flush outranks push, pop and issue in the same cycle.

## Timing
- Reset (RSTn low at edge): count=0, FSM=FETCH, out_valid=0, halted=0, opcode/operand/cls/alu_op/alu_mode=0, in_ready=1 the cycle after release. Reset mid-instruction discards partial operands.
- Latency: byte accepted at edge E0; popped at E1; 1-byte instruction out_valid high after E1. OPW=8 LD with both bytes queued: out_valid after E2; OPW=16: after E3.
- Sustained throughput: one 1-byte instruction per cycle while queue non-empty and out_ready=1.
- All outputs registered; no combinational path from out_ready or in_valid to outputs except in_ready (from flush).

## Configuration
- IR_ILLEGAL_TRAP_EN defined: ILLEGAL opcodes issue with cls=7; their handshake sets halted exactly like HALT.
- Undefined: ILLEGAL opcodes are popped and dropped (never issued, no halt); FSM stays in FETCH.

## Test plan
- Reset with junk queued, RSTn low one edge → count=0, out_valid=0, halted=0, in_ready=1.
- Push 0x92, 0x9F, 0xA9 with out_ready=1 → issues cls=1 {op0,mode0}, {op3,mode1}, {op5,mode3} on consecutive cycles.
- OPW=16: push 0x90, 0x34, 0x12, then 0xC1 with operand bytes delayed 3 cycles → LD mode0 operand=0x1234; JMP stalls in OPND, then issues operand as sent.
- DEPTH=4, out_ready=0, push 6 bytes → in_ready low at count=4, no byte lost or duplicated after out_ready rises.
- Push 0xC0, 0x55, assert flush during OPND together with in_valid → queue empty, no issue, pushed byte dropped.
- Push 0x00 then 0xFF → with IR_ILLEGAL_TRAP_EN: cls=7 issued, halted=1, 0xFF never issued; without: 0x00 dropped, cls=4 issued, halted=1, in_ready=0.
